// File: rtl/vga_window_compositor.sv
// -----------------------------------------------------------------------------
// vga_window_compositor
//
// Three-stage pixel compositor for the VGA clock/alarm display. Up to NUM_WIN
// rectangular bitmap windows, all fetched from one shared synchronous image
// ROM, are layered over a background colour. Window 0 has highest priority.
//
//   stage 1 : hit detect, priority resolve, window-relative dx/dy
//   stage 2 : ROM address = base + dy*w + dx (registered, drives the ROM)
//   stage 3 : colour select against rom_data (ROM has 1-cycle read latency)
//
// Optional feature macro: VGA_COMP_BLINK_EN
//   defined   : free-running blink timer, per-window blinking, alarm inversion
//   undefined : no timer, blink_phase is constant 0 (win_blink/alarm_on inert)
//
// Ports
//   clk, rst                 pixel clock, asynchronous active-low reset
//   pixel_x, pixel_y         current pixel coordinates (10 bits each)
//   video_on, hsync, vsync   sync-generator outputs for the current pixel
//   win_x0/y0/w/h            flattened geometry, window i at [10i+9:10i]
//   win_base                 flattened ROM base address per window
//   win_blink                per-window blink enable
//   cursor_en, cursor_win    highlight enable and highlighted window index
//   alarm_on                 alarm active (whole-screen inversion on blink)
//   bg_color                 background colour
//   rom_addr / rom_data      image ROM address out / data in
//   color                    composited pixel, 3 cycles after pixel_x/y
//   hsync_o, vsync_o,
//   video_on_o               sync signals delayed to align with color
// -----------------------------------------------------------------------------
module vga_window_compositor #(
  parameter int                 NUM_WIN   = 5,
  parameter int                 COLOR_W   = 8,
  parameter int                 ADDR_W    = 15,
  parameter int                 BLINK_DIV = 16666666,
  parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(8'hE3),
  localparam int                IDX_W     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic                      video_on,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [NUM_WIN*10-1:0]     win_x0,
  input  logic [NUM_WIN*10-1:0]     win_y0,
  input  logic [NUM_WIN*10-1:0]     win_w,
  input  logic [NUM_WIN*10-1:0]     win_h,
  input  logic [NUM_WIN*ADDR_W-1:0] win_base,
  input  logic [NUM_WIN-1:0]        win_blink,
  input  logic                      cursor_en,
  input  logic [IDX_W-1:0]          cursor_win,
  input  logic                      alarm_on,
  input  logic [COLOR_W-1:0]        bg_color,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [COLOR_W-1:0]        rom_data,
  output logic [COLOR_W-1:0]        color,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      video_on_o
);

  localparam int SUM_W = (ADDR_W > 20) ? ADDR_W : 20;

  // ---------------------------------------------------------------------------
  // Stage 1: hit detect
  // ---------------------------------------------------------------------------
  // 11-bit end coordinates so x0+w cannot wrap back into range.
  function automatic logic win_hit(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] x0, input logic [9:0] y0,
                                   input logic [9:0] w,  input logic [9:0] h);
    logic [10:0] x_end;
    logic [10:0] y_end;
    x_end = {1'b0, x0} + {1'b0, w};
    y_end = {1'b0, y0} + {1'b0, h};
    return (w != 10'd0) && (h != 10'd0) &&
           (px >= x0) && ({1'b0, px} < x_end) &&
           (py >= y0) && ({1'b0, py} < y_end);
  endfunction

  logic             hit_c;
  logic [IDX_W-1:0] idx_c;
  logic [9:0]       dx_c;
  logic [9:0]       dy_c;

  // Scan from lowest priority upwards so the lowest hit index is the last
  // assignment and therefore wins.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    dx_c  = '0;
    dy_c  = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (win_hit(pixel_x, pixel_y, win_x0[10*i +: 10], win_y0[10*i +: 10],
                  win_w[10*i +: 10], win_h[10*i +: 10])) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
        dx_c  = pixel_x - win_x0[10*i +: 10];
        dy_c  = pixel_y - win_y0[10*i +: 10];
      end
    end
  end

  logic             hit_s1;
  logic [IDX_W-1:0] idx_s1;
  logic [9:0]       dx_s1;
  logic [9:0]       dy_s1;
  logic             vid_s1;
  logic             hs_s1;
  logic             vs_s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_s1 <= 1'b0;
      idx_s1 <= '0;
      dx_s1  <= '0;
      dy_s1  <= '0;
      vid_s1 <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
    end else begin
      hit_s1 <= hit_c;
      idx_s1 <= idx_c;
      dx_s1  <= dx_c;
      dy_s1  <= dy_c;
      vid_s1 <= video_on;
      hs_s1  <= hsync;
      vs_s1  <= vsync;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: ROM address
  // ---------------------------------------------------------------------------
  // Width and base are taken from the live geometry inputs for the window
  // resolved in stage 1.
  logic [9:0]        w_sel;
  logic [ADDR_W-1:0] base_sel;
  logic [19:0]       prod;
  logic [SUM_W-1:0]  addr_sum;

  always_comb begin
    w_sel    = '0;
    base_sel = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (idx_s1 == IDX_W'(i)) begin
        w_sel    = win_w[10*i +: 10];
        base_sel = win_base[ADDR_W*i +: ADDR_W];
      end
    end
  end

  assign prod     = dy_s1 * w_sel;
  assign addr_sum = SUM_W'(base_sel) + SUM_W'(prod) + SUM_W'(dx_s1);

  logic             hit_s2;
  logic [IDX_W-1:0] idx_s2;
  logic             vid_s2;
  logic             hs_s2;
  logic             vs_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      hit_s2   <= 1'b0;
      idx_s2   <= '0;
      vid_s2   <= 1'b0;
      hs_s2    <= 1'b1;
      vs_s2    <= 1'b1;
    end else begin
      rom_addr <= addr_sum[ADDR_W-1:0];
      hit_s2   <= hit_s1;
      idx_s2   <= idx_s1;
      vid_s2   <= vid_s1;
      hs_s2    <= hs_s1;
      vs_s2    <= vs_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 alignment registers; rom_data arrives in the same cycle.
  // ---------------------------------------------------------------------------
  logic             hit_s3;
  logic [IDX_W-1:0] idx_s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_s3     <= 1'b0;
      idx_s3     <= '0;
      video_on_o <= 1'b0;
      hsync_o    <= 1'b1;
      vsync_o    <= 1'b1;
    end else begin
      hit_s3     <= hit_s2;
      idx_s3     <= idx_s2;
      video_on_o <= vid_s2;
      hsync_o    <= hs_s2;
      vsync_o    <= vs_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink timer
  // ---------------------------------------------------------------------------
  logic blink_phase;

`ifdef VGA_COMP_BLINK_EN
  localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end
`else
  logic unused_blink_div;

  assign blink_phase      = 1'b0;
  assign unused_blink_div = (BLINK_DIV > 0);
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: colour select
  // ---------------------------------------------------------------------------
  logic               blink_sel;
  logic               cursor_hit;
  logic [COLOR_W-1:0] color_c;

  always_comb begin
    blink_sel = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (idx_s3 == IDX_W'(i)) begin
        blink_sel = win_blink[i];
      end
    end
  end

  // Out-of-range cursor indices highlight nothing.
  assign cursor_hit = cursor_en && (int'(cursor_win) < NUM_WIN) &&
                      (idx_s3 == cursor_win);

  // Key colour shows background directly; it never reveals a lower window.
  always_comb begin
    color_c = bg_color;
    if (!hit_s3 || (rom_data == KEY_COLOR)) begin
      color_c = bg_color;
    end else if (blink_sel && blink_phase) begin
      color_c = bg_color;
    end else if (cursor_hit) begin
      color_c = ~rom_data;
    end else begin
      color_c = rom_data;
    end
    if (alarm_on && blink_phase) begin
      color_c = ~color_c;
    end
    if (!video_on_o) begin
      color_c = '0;
    end
  end

  assign color = color_c;

endmodule

// File: tb/tb_vga_window_compositor.sv
module tb_vga_window_compositor;

  localparam int NUM_WIN = 5;
  localparam int COLOR_W = 8;
  localparam int ADDR_W  = 15;
  localparam int IDX_W   = 3;
  localparam logic [7:0] BG  = 8'h12;
  localparam logic [7:0] KEY = 8'hE3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [9:0]                pixel_x;
  logic [9:0]                pixel_y;
  logic                      video_on;
  logic                      hsync;
  logic                      vsync;
  logic [NUM_WIN*10-1:0]     win_x0;
  logic [NUM_WIN*10-1:0]     win_y0;
  logic [NUM_WIN*10-1:0]     win_w;
  logic [NUM_WIN*10-1:0]     win_h;
  logic [NUM_WIN*ADDR_W-1:0] win_base;
  logic [NUM_WIN-1:0]        win_blink;
  logic                      cursor_en;
  logic [IDX_W-1:0]          cursor_win;
  logic                      alarm_on;
  logic [COLOR_W-1:0]        bg_color;
  logic [ADDR_W-1:0]         rom_addr;
  logic [COLOR_W-1:0]        rom_data;
  logic [COLOR_W-1:0]        color;
  logic                      hsync_o;
  logic                      vsync_o;
  logic                      video_on_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rom_mem [0:32767];

  vga_window_compositor #(
    .NUM_WIN  (NUM_WIN),
    .COLOR_W  (COLOR_W),
    .ADDR_W   (ADDR_W),
    .BLINK_DIV(4),
    .KEY_COLOR(KEY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .video_on  (video_on),
    .hsync     (hsync),
    .vsync     (vsync),
    .win_x0    (win_x0),
    .win_y0    (win_y0),
    .win_w     (win_w),
    .win_h     (win_h),
    .win_base  (win_base),
    .win_blink (win_blink),
    .cursor_en (cursor_en),
    .cursor_win(cursor_win),
    .alarm_on  (alarm_on),
    .bg_color  (bg_color),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .color     (color),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .video_on_o(video_on_o)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Reference blink phase: BLINK_DIV=4 gives a toggle every 4 clocks.
  logic       m_phase;
`ifdef VGA_COMP_BLINK_EN
  logic [1:0] m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   <= 2'd0;
      m_phase <= 1'b0;
    end else if (m_cnt == 2'd3) begin
      m_cnt   <= 2'd0;
      m_phase <= ~m_phase;
    end else begin
      m_cnt   <= m_cnt + 2'd1;
    end
  end
`else
  assign m_phase = 1'b0;
`endif

  function automatic logic [7:0] rom_val(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_win(input int i, input int x0, input int y0, input int w,
                         input int h, input int base);
    win_x0[10*i +: 10]         = 10'(x0);
    win_y0[10*i +: 10]         = 10'(y0);
    win_w[10*i +: 10]          = 10'(w);
    win_h[10*i +: 10]          = 10'(h);
    win_base[ADDR_W*i +: ADDR_W] = ADDR_W'(base);
  endtask

  // Present a pixel, hold it, check rom_addr at n+2 and color at n+3.
  task automatic run_pixel(input string tag, input int x, input int y,
                           input logic vid, input logic has_addr,
                           input int exp_addr, input logic [7:0] exp_color);
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = vid;
    repeat (2) @(posedge clk);
    #1;
    if (has_addr) chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    @(posedge clk);
    #1;
    chk({tag, "_color"}, 32'(color), 32'(exp_color));
  endtask

  logic [9:0] hs_pat;
  logic [9:0] vs_pat;
  logic [9:0] vo_pat;
  logic [7:0] exp_c;

  initial begin
    for (int a = 0; a < 32768; a++) rom_mem[a] = rom_val(a);
    rom_mem[1705]  = KEY;
    rom_mem[10066] = KEY;

    rst        = 1'b0;
    pixel_x    = '0;
    pixel_y    = '0;
    video_on   = 1'b0;
    hsync      = 1'b1;
    vsync      = 1'b1;
    win_x0     = '0;
    win_y0     = '0;
    win_w      = '0;
    win_h      = '0;
    win_base   = '0;
    win_blink  = '0;
    cursor_en  = 1'b0;
    cursor_win = '0;
    alarm_on   = 1'b0;
    bg_color   = BG;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_color",  32'(color), 32'h0);
    chk("rst_addr",   32'(rom_addr), 32'h0);
    chk("rst_hsync",  32'(hsync_o), 32'h1);
    chk("rst_vsync",  32'(vsync_o), 32'h1);
    chk("rst_video",  32'(video_on_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single window.
    set_win(0, 85, 48, 95, 40, 0);
    run_pixel("w0_basic", 90, 50, 1'b1, 1'b1, 195, 8'h99);
    run_pixel("x179_hit", 179, 50, 1'b1, 1'b1, 284, 8'h46);
    run_pixel("x180_miss", 180, 50, 1'b1, 1'b0, 0, BG);
    run_pixel("y87_hit", 90, 87, 1'b1, 1'b1, 3710, 8'h24);
    run_pixel("y88_miss", 90, 88, 1'b1, 1'b0, 0, BG);
    run_pixel("x84_miss", 84, 50, 1'b1, 1'b0, 0, BG);

    // Overlapping windows; window 0 wins, key colour never falls through.
    set_win(1, 170, 60, 50, 20, 5000);
    run_pixel("ovl_key", 175, 65, 1'b1, 1'b1, 1705, BG);
    run_pixel("ovl_prio", 172, 65, 1'b1, 1'b1, 1702, 8'hFC);
    run_pixel("w1_only", 200, 65, 1'b1, 1'b1, 5280, 8'hFA);

    // Cursor highlight.
    set_win(2, 300, 200, 20, 10, 10000);
    cursor_en  = 1'b1;
    cursor_win = 3'd2;
    run_pixel("cur_inv", 305, 203, 1'b1, 1'b1, 10065, 8'hF4);
    run_pixel("cur_key", 306, 203, 1'b1, 1'b1, 10066, BG);
    run_pixel("cur_other", 90, 50, 1'b1, 1'b0, 0, 8'h99);
    cursor_win = 3'd5;
    run_pixel("cur_oob", 305, 203, 1'b1, 1'b0, 0, 8'h0B);
    cursor_en  = 1'b0;

    // Zero-size window is never hit.
    set_win(3, 0, 0, 0, 10, 20000);
    run_pixel("w_zero", 0, 0, 1'b1, 1'b0, 0, BG);

    // Blanking.
    run_pixel("vid_off", 90, 50, 1'b0, 1'b0, 0, 8'h00);
    chk("vid_off_o", 32'(video_on_o), 32'h0);

    // Sync delay alignment.
    hs_pat = 10'b1011001011;
    vs_pat = 10'b0110110001;
    vo_pat = 10'b1101011010;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 10) begin
        hsync    = hs_pat[k];
        vsync    = vs_pat[k];
        video_on = vo_pat[k];
      end
      @(posedge clk);
      #1;
      if (k >= 2) begin
        chk("hsync_dly", 32'(hsync_o), 32'(hs_pat[k-2]));
        chk("vsync_dly", 32'(vsync_o), 32'(vs_pat[k-2]));
        chk("video_dly", 32'(video_on_o), 32'(vo_pat[k-2]));
      end
    end

    // Mid-frame asynchronous reset.
    @(negedge clk);
    pixel_x  = 10'd90;
    pixel_y  = 10'd50;
    video_on = 1'b1;
    hsync    = 1'b0;
    vsync    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_color", 32'(color), 32'h99);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_color", 32'(color), 32'h0);
    chk("mrst_video", 32'(video_on_o), 32'h0);
    chk("mrst_hsync", 32'(hsync_o), 32'h1);
    chk("mrst_addr",  32'(rom_addr), 32'h0);
    @(negedge clk);
    rst   = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("refill_color", 32'(color), (k == 3) ? 32'h99 : 32'h0);
    end

    // Window and alarm blinking.
    win_blink = 5'b00001;
    alarm_on  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      exp_c = m_phase ? ~BG : 8'h99;
      chk("blink_win", 32'(color), 32'(exp_c));
    end
    @(negedge clk);
    pixel_x = 10'd400;
    pixel_y = 10'd400;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      exp_c = m_phase ? ~BG : BG;
      chk("blink_bg", 32'(color), 32'(exp_c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
